// File: rtl/pipe_transfer_reg_pkg.sv
// Shared pipeline-register constants: NOP encoding, handshake state encoding
// and the per-entry load/bubble control bundle.
package pipe_transfer_reg_pkg;

    localparam int unsigned INSTR_NOP_W = 32;
    localparam logic [INSTR_NOP_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Control bundle for one entry register; bubble wins over load.
    typedef struct packed {
        logic load;
        logic bubble;
    } entry_ctrl_t;

    // Number of valid entries held in a given state.
    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_transfer_reg_entry.sv
// One pipeline entry (payload, flags, instruction) captured on the falling
// edge; a bubble load resets it to data 0 / flags 0 / NOP.
module pipe_entry_reg
    import pipe_transfer_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned FLAG_W = 1,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  entry_ctrl_t       ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [FLAG_W-1:0] d_flags,
    input  logic [INST_W-1:0] d_inst,
    output logic [DATA_W-1:0] q_data,
    output logic [FLAG_W-1:0] q_flags,
    output logic [INST_W-1:0] q_inst
);

    localparam logic [INST_W-1:0] NOP_INST = INST_W'(INSTR_NOP);

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_data  <= '0;
            q_flags <= '0;
            q_inst  <= NOP_INST;
        end else if (ctrl.bubble) begin
            q_data  <= '0;
            q_flags <= '0;
            q_inst  <= NOP_INST;
        end else if (ctrl.load) begin
            q_data  <= d_data;
            q_flags <= d_flags;
            q_inst  <= d_inst;
        end
    end

endmodule

// File: rtl/pipe_transfer_reg.sv
// Stage-boundary transfer register: valid/ready handshake with a one-entry
// skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_transfer_reg
    import pipe_transfer_reg_pkg::*;
#(
    parameter int unsigned N_DATA = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FLAG_W = 1,
    parameter int unsigned INST_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0]        in_flags,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0]        out_flags,
    output logic [INST_W-1:0]        out_inst,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned PAY_W = N_DATA * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_e state_q;
    pipe_state_e state_nxt;

    entry_ctrl_t main_ctrl;
    entry_ctrl_t skid_ctrl;
    logic        main_from_skid;
    logic        accept;
    logic        drain;

    logic [PAY_W-1:0]  skid_data;
    logic [FLAG_W-1:0] skid_flags;
    logic [INST_W-1:0] skid_inst;

    logic [PAY_W-1:0]  main_d_data;
    logic [FLAG_W-1:0] main_d_flags;
    logic [INST_W-1:0] main_d_inst;

    // in_ready/out_valid are flops, so neither handshake side sees a
    // combinational path from the other.
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Next state and entry-register controls; flush overrides everything.
    always_comb begin
        state_nxt      = state_q;
        main_ctrl      = '0;
        skid_ctrl      = '0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt        = ST_EMPTY;
            main_ctrl.bubble = 1'b1;
            skid_ctrl.bubble = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt      = ST_ONE;
                        main_ctrl.load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ctrl.load = 1'b1;
                    end else if (accept) begin
                        state_nxt      = ST_FULL;
                        skid_ctrl.load = 1'b1;
                    end else if (drain) begin
                        state_nxt        = ST_EMPTY;
                        main_ctrl.bubble = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_nxt        = ST_ONE;
                        main_ctrl.load   = 1'b1;
                        main_from_skid   = 1'b1;
                        skid_ctrl.bubble = 1'b1;
                    end
                end
                default: begin
                    state_nxt        = ST_EMPTY;
                    main_ctrl.bubble = 1'b1;
                    skid_ctrl.bubble = 1'b1;
                end
            endcase
        end
    end

    // State plus handshake/occupancy flags decoded from the next state.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_q   <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
            occupancy <= state_occupancy(state_nxt);
        end
    end

    // Stalled edges only; a flushed edge is not a stall.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign main_d_data  = main_from_skid ? skid_data  : in_data;
    assign main_d_flags = main_from_skid ? skid_flags : in_flags;
    assign main_d_inst  = main_from_skid ? skid_inst  : in_inst;

    pipe_entry_reg #(
        .DATA_W (PAY_W),
        .FLAG_W (FLAG_W),
        .INST_W (INST_W)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (main_ctrl),
        .d_data  (main_d_data),
        .d_flags (main_d_flags),
        .d_inst  (main_d_inst),
        .q_data  (out_data),
        .q_flags (out_flags),
        .q_inst  (out_inst)
    );

    pipe_entry_reg #(
        .DATA_W (PAY_W),
        .FLAG_W (FLAG_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (skid_ctrl),
        .d_data  (in_data),
        .d_flags (in_flags),
        .d_inst  (in_inst),
        .q_data  (skid_data),
        .q_flags (skid_flags),
        .q_inst  (skid_inst)
    );

endmodule

// File: doc/pipe_transfer_reg.md
# pipe_transfer_reg

Parametrised pipeline transfer register between two CPU stages, generalising the fixed stage-to-stage latch to N data words, a flag field and an instruction field. Adds a valid/ready handshake with a one-entry skid buffer, so `in_ready` depends only on registered state. It also adds a flush that injects a NOP bubble and a saturating back-pressure counter. It sits on every stage boundary (F/D, D/X, X/MW), capturing on the falling edge of `clk` like the rest of the pipeline registers.

## Interface
- `N_DATA`, 3: number of payload words (e.g. pc, alu_out, rs2d).
- `DATA_W`, 32: width of each payload word.
- `FLAG_W`, 1: width of sideband flag field (e.g. jump).
- `INST_W`, 32: instruction width.
- `CNT_W`, 16: width of stall-cycle counter.

- `clk`  in  1  clock; all state changes on falling edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill all held entries and inject a bubble.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  block can accept an entry.
- `in_data`  in  N_DATA*DATA_W  payload, word k at bits [k*DATA_W +: DATA_W].
- `in_flags`  in  FLAG_W  sideband flags.
- `in_inst`  in  INST_W  instruction.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  downstream accepts (low = stall).
- `out_data`  out  N_DATA*DATA_W  held payload.
- `out_flags`  out  FLAG_W  held flags.
- `out_inst`  out  INST_W  held instruction; INSTR_NOP when empty.
- `occupancy`  out  2  entries held (0..2).
- `stall_cnt`  out  CNT_W  saturating count of stalled edges.

## Operation
- Two entry registers: main (drives outputs) and skid.
- States: EMPTY, ONE (main valid), FULL (main+skid valid). `occupancy` = 0/1/2 respectively.
- `in_ready` = (state != FULL). `out_valid` = (state != EMPTY). Both are pure functions of state.
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`. Both are sampled at the falling edge.
- EMPTY: accept -> ONE, main <= in.
- ONE: accept & drain -> ONE, main <= in. Accept only -> FULL, skid <= in. Drain only -> EMPTY, main <= bubble. Neither -> hold.
- FULL: drain -> ONE, main <= skid, skid <= bubble. No drain -> hold. Input is never accepted in FULL.
- Bubble = data 0, flags 0, inst INSTR_NOP. Whenever state is EMPTY, main holds a bubble, so outputs show a NOP.
- Flush has priority over accept/drain. At the edge: state <= EMPTY, main and skid <= bubble. Any entry offered or drained that edge is discarded; downstream must treat it as not transferred.
- `stall_cnt` increments at each edge where `out_valid && !out_ready && !flush`. It saturates at 2^CNT_W-1, is cleared only by reset, and is unaffected by flush.
- Payload fields are stored verbatim; no arithmetic on data.

## Timing
- Reset (async assert, any time, including mid-transfer): state EMPTY, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_flags`=0, `out_inst`=INSTR_NOP, `occupancy`=0, `stall_cnt`=0. Deassertion takes effect at the next falling edge.
- Latency: an accepted entry appears on outputs after the same falling edge (1 half-cycle capture, same as the existing stage registers).
- Throughput: 1 entry per cycle with `out_ready` held high; occupancy stays ≤1.
- A single stall cycle is absorbed by the skid entry. `in_ready` falls in the cycle after the skid fills, with no combinational path from `out_ready` to `in_ready`.
- After flush: `out_valid`=0 and `in_ready`=1 in the next cycle.

## Structure
- INSTR_NOP (32'h0000_0013) and the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) live in the shared constants header/package used by all stages.
- Sub-module `pipe_entry_reg`: one entry register (data/flags/inst) with load and bubble-load controls. It is instantiated twice (main, skid).
- Top level holds the FSM and counter.

## Test plan
- Reset: assert `reset_n`=0 mid-FULL -> immediately `out_inst`=32'h13, `out_valid`=0, `in_ready`=1, `occupancy`=0, `stall_cnt`=0.
- Streaming: 8 entries with inst 1..8, `out_ready`=1 -> outputs 1..8 on consecutive cycles, `occupancy`≤1, `in_ready` never low.
- Back-pressure: send inst A,B,C while `out_ready`=0 -> A held, B in skid, `in_ready`=0, C not accepted. Raise `out_ready` -> A, B, C out in order, none lost or duplicated.
- Flush in FULL with `in_valid`=1 -> next cycle `occupancy`=0, `out_inst`=NOP, `out_data`=0; offered entry is not seen later.
- Counter: CNT_W=4, hold `out_valid`=1 and `out_ready`=0 for 20 edges -> `stall_cnt`=15 and stays. Flush -> stays 15.
- Drain to empty: single entry, drained -> `out_inst` returns to NOP, `out_valid`=0 the next cycle.
